// File: rtl/crc_stream_rx.sv
// crc_stream_rx: byte-serial CRC-32 frame checker.
// Holds back a 4-byte trailer, forwards payload while the CRC runs, and strobes a verdict.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   udp_rx[7:0]          input byte from the link
//   udp_rx_valid         udp_rx holds a byte this cycle
//   udp_rx_first/last    frame delimiters, sampled only with valid
//   to_udp[7:0]          forwarded payload byte (zero when not valid)
//   to_udp_valid         to_udp holds a byte
//   to_udp_first/last    first / last payload byte of the frame
//   crc_valid            one-cycle verdict strobe
//   crc_check            1 = CRC matched, qualified by crc_valid
module crc_stream_rx #(
    parameter logic [31:0] POLY      = 32'h973AFB51,
    parameter int          MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] udp_rx,
    input  logic       udp_rx_valid,
    input  logic       udp_rx_first,
    input  logic       udp_rx_last,
    output logic [7:0] to_udp,
    output logic       to_udp_valid,
    output logic       to_udp_first,
    output logic       to_udp_last,
    output logic       crc_valid,
    output logic       crc_check
);

    localparam int CW = $clog2(MAX_BYTES + 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FILL    = 2'd1;
    localparam logic [1:0] S_STREAM  = 2'd2;
    localparam logic [1:0] S_VERDICT = 2'd3;

    logic [1:0]    state, state_d;
    logic [31:0]   crc, crc_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [31:0]   dl, dl_d;

    logic [7:0] out_d;
    logic       ov_d, of_d, ol_d, cv_d, cc_d;

    logic [31:0] shifted;
    logic [7:0]  oldest;

    // Eight MSB-first bit steps folded into one cycle.
    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[31] ^ b[i];
            r  = {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
        end
        return r;
    endfunction

    // dl[31:24] is the oldest byte; after the last byte dl is the trailer.
    assign shifted = {dl[23:0], udp_rx};
    assign oldest  = dl[31:24];

    always_comb begin
        state_d = state;
        crc_d   = crc;
        cnt_d   = cnt;
        dl_d    = dl;
        out_d   = 8'h00;
        ov_d    = 1'b0;
        of_d    = 1'b0;
        ol_d    = 1'b0;
        cv_d    = 1'b0;
        cc_d    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (udp_rx_valid && udp_rx_first) begin
                    dl_d  = shifted;
                    crc_d = 32'h0;
                    cnt_d = CW'(1);
                    if (udp_rx_last) begin
                        cv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL, S_STREAM: begin
                if (udp_rx_valid) begin
                    if (udp_rx_first) begin
                        // Abort the running frame, restart on this byte.
                        cv_d    = 1'b1;
                        dl_d    = shifted;
                        crc_d   = 32'h0;
                        cnt_d   = CW'(1);
                        state_d = udp_rx_last ? S_IDLE : S_FILL;
                    end else if (cnt == CW'(MAX_BYTES)) begin
                        // Over-length: abort, drop the rest until next first.
                        cv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else if (cnt < CW'(4)) begin
                        dl_d  = shifted;
                        cnt_d = cnt + CW'(1);
                        if (udp_rx_last) begin
                            cv_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        // Byte 5 onward pushes the oldest byte out as payload.
                        dl_d    = shifted;
                        cnt_d   = cnt + CW'(1);
                        crc_d   = crc_byte(crc, oldest);
                        out_d   = oldest;
                        ov_d    = 1'b1;
                        of_d    = (cnt == CW'(4));
                        ol_d    = udp_rx_last;
                        state_d = udp_rx_last ? S_VERDICT : S_STREAM;
                    end
                end
            end
            S_VERDICT: begin
                cv_d    = 1'b1;
                cc_d    = (~crc == dl);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            crc          <= 32'h0;
            cnt          <= '0;
            dl           <= 32'h0;
            to_udp       <= 8'h00;
            to_udp_valid <= 1'b0;
            to_udp_first <= 1'b0;
            to_udp_last  <= 1'b0;
            crc_valid    <= 1'b0;
            crc_check    <= 1'b0;
        end else begin
            state        <= state_d;
            crc          <= crc_d;
            cnt          <= cnt_d;
            dl           <= dl_d;
            to_udp       <= out_d;
            to_udp_valid <= ov_d;
            to_udp_first <= of_d;
            to_udp_last  <= ol_d;
            crc_valid    <= cv_d;
            crc_check    <= cc_d;
        end
    end

endmodule

// File: tb/tb_crc_stream_rx.sv
// tb_crc_stream_rx: directed frames against a frame-level reference model,
// with hand-computed literal expectations per frame.
module tb_crc_stream_rx;

    localparam logic [31:0] POLY = 32'h973AFB51;
    localparam int          MAX  = 64;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] udp_rx;
    logic       udp_rx_valid, udp_rx_first, udp_rx_last;
    logic [7:0] to_udp;
    logic       to_udp_valid, to_udp_first, to_udp_last;
    logic       crc_valid, crc_check;

    int checks = 0;
    int errors = 0;

    crc_stream_rx #(.POLY(POLY), .MAX_BYTES(MAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .udp_rx(udp_rx),
        .udp_rx_valid(udp_rx_valid),
        .udp_rx_first(udp_rx_first),
        .udp_rx_last(udp_rx_last),
        .to_udp(to_udp),
        .to_udp_valid(to_udp_valid),
        .to_udp_first(to_udp_first),
        .to_udp_last(to_udp_last),
        .crc_valid(crc_valid),
        .crc_check(crc_check)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CRC over a whole byte list, straight from the bit-serial definition.
    function automatic logic [31:0] crc_calc(input bq_t q);
        logic [31:0] c;
        logic        fb;
        c = 32'h0;
        foreach (q[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[31] ^ q[i][k];
                c  = {c[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
            end
        end
        return c;
    endfunction

    function automatic bq_t make_frame(input bq_t p);
        bq_t         q;
        logic [31:0] t;
        q = p;
        t = ~crc_calc(p);
        q.push_back(t[31:24]);
        q.push_back(t[23:16]);
        q.push_back(t[15:8]);
        q.push_back(t[7:0]);
        return q;
    endfunction

    // Whole received frame: payload is all but the final four bytes.
    function automatic logic verdict_of(input bq_t q);
        bq_t         p;
        logic [31:0] t;
        int          n;
        n = q.size();
        p = {};
        for (int i = 0; i < n - 4; i++) p.push_back(q[i]);
        t = {q[n-4], q[n-3], q[n-2], q[n-1]};
        return (~crc_calc(p) == t);
    endfunction

    // Reference model: expected outputs for the cycle after each edge.
    logic [7:0] e_d;
    logic       e_v, e_f, e_l, e_cv, e_cc;
    bq_t        fq;
    logic       in_frame, pend, pend_val;

    initial begin
        int n;
        e_d = 0; e_v = 0; e_f = 0; e_l = 0; e_cv = 0; e_cc = 0;
        in_frame = 0; pend = 0; pend_val = 0;
        fq = {};
        forever begin
            @(posedge clk or negedge rst_n);
            e_d = 0; e_v = 0; e_f = 0; e_l = 0; e_cv = 0; e_cc = 0;
            if (!rst_n) begin
                in_frame = 0; pend = 0; fq = {};
            end else if (pend) begin
                e_cv = 1; e_cc = pend_val; pend = 0;
            end else if (udp_rx_valid) begin
                if (udp_rx_first) begin
                    if (in_frame || udp_rx_last) e_cv = 1;
                    fq = {udp_rx};
                    in_frame = !udp_rx_last;
                end else if (in_frame) begin
                    if (fq.size() >= MAX) begin
                        e_cv = 1; in_frame = 0;
                    end else begin
                        fq.push_back(udp_rx);
                        n = fq.size();
                        if (n >= 5) begin
                            e_d = fq[n-5]; e_v = 1;
                            e_f = (n == 5); e_l = udp_rx_last;
                            if (udp_rx_last) begin
                                pend = 1; pend_val = verdict_of(fq);
                                in_frame = 0;
                            end
                        end else if (udp_rx_last) begin
                            e_cv = 1; in_frame = 0;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            checks++;
            if ({to_udp_valid, to_udp_first, to_udp_last, crc_valid} !==
                {e_v, e_f, e_l, e_cv} ||
                (e_v && to_udp !== e_d) || (e_cv && crc_check !== e_cc)) begin
                errors++;
                $display("FAIL cycle @%0t: got v%b f%b l%b d%h cv%b cc%b expected v%b f%b l%b d%h cv%b cc%b",
                         $time, to_udp_valid, to_udp_first, to_udp_last, to_udp,
                         crc_valid, crc_check, e_v, e_f, e_l, e_d, e_cv, e_cc);
            end
        end
    end

    // Per-frame tallies for the literal checks.
    int   ocnt, vcnt;
    logic vchk;
    initial begin
        ocnt = 0; vcnt = 0; vchk = 0;
        forever begin
            @(negedge clk);
            if (to_udp_valid) ocnt++;
            if (crc_valid) begin
                vcnt++;
                vchk = crc_check;
            end
        end
    end

    task automatic drive(input logic [7:0] b, input logic f, input logic l);
        @(negedge clk);
        udp_rx = b; udp_rx_valid = 1; udp_rx_first = f; udp_rx_last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            udp_rx = 0; udp_rx_valid = 0; udp_rx_first = 0; udp_rx_last = 0;
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        #2;
        ocnt = 0; vcnt = 0;
    endtask

    task automatic send_frame(input bq_t q, input int gap, input bit do_last);
        for (int i = 0; i < q.size(); i++) begin
            drive(q[i], i == 0, do_last && (i == q.size() - 1));
            if (gap > 0) idle(gap);
        end
        idle(5);
    endtask

    task automatic expect_frame(input string name, input int o, input int v,
                                input logic c);
        check({name, "_out"}, ocnt, o);
        check({name, "_nverdict"}, vcnt, v);
        if (v > 0) check({name, "_verdict"}, vchk, c);
    endtask

    initial begin
        bq_t q;
        rst_n = 0; udp_rx = 0; udp_rx_valid = 0;
        udp_rx_first = 0; udp_rx_last = 0;

        q = {8'h01};
        check("pin_crc_01", crc_calc(q), 32'h973AFB51);
        q = {8'h02};
        check("pin_crc_02", crc_calc(q), 32'hB94F0DF3);
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        check("pin_crc_zero", crc_calc(q), 32'h0);

        repeat (3) @(negedge clk);
        check("reset_outs",
              {to_udp, to_udp_valid, to_udp_first, to_udp_last, crc_valid, crc_check},
              14'h0);
        rst_n = 1;
        idle(2);

        clear_mon();
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(q, 0, 1);
        expect_frame("t1_zero", 5, 1, 1'b1);

        clear_mon();
        q = {8'h01, 8'h68, 8'hC5, 8'h04, 8'hAE};
        send_frame(q, 0, 1);
        expect_frame("t2_one", 1, 1, 1'b1);

        clear_mon();
        q = {8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
        send_frame(q, 0, 1);
        expect_frame("t3_bad", 1, 1, 1'b0);

        clear_mon();
        q = {8'hAA, 8'hBB, 8'hCC};
        send_frame(q, 0, 1);
        expect_frame("t4_runt", 0, 1, 1'b0);

        clear_mon();
        q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame(make_frame(q), 1, 1);
        expect_frame("t5_gaps", 5, 1, 1'b1);

        clear_mon();
        for (int i = 0; i < 7; i++) drive(8'h10 + 8'(i), i == 0, 0);
        drive(8'h20, 1, 0);
        drive(8'h21, 0, 0);
        drive(8'h22, 0, 0);
        idle(1);
        expect_frame("t6_abort", 3, 1, 1'b0);
        clear_mon();
        @(negedge clk);
        rst_n = 0;
        idle(2);
        check("t6_in_reset",
              {to_udp, to_udp_valid, to_udp_first, to_udp_last, crc_valid, crc_check},
              14'h0);
        rst_n = 1;
        idle(3);
        check("t6_no_cut_verdict", vcnt, 0);
        clear_mon();
        q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(q, 0, 1);
        expect_frame("t6_after", 5, 1, 1'b1);

        clear_mon();
        q = {};
        for (int i = 0; i < MAX + 1; i++) q.push_back(8'(i * 3 + 1));
        send_frame(q, 0, 0);
        drive(8'h77, 0, 1);
        idle(4);
        expect_frame("t7_overlong", MAX - 4, 1, 1'b0);

        clear_mon();
        q = {};
        for (int i = 0; i < MAX - 4; i++) q.push_back(8'(i * 7 + 5));
        send_frame(make_frame(q), 0, 1);
        expect_frame("t8_maxlen", MAX - 4, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
